// File: rtl/prog_delay_line.sv
// prog_delay_line: runtime-programmable sample delay line.
// Delays a DATA_WIDTH stream plus its valid tag by 1..2**DEPTH_BITS enabled
// cycles using a circular buffer. Supports stall (en) and flushes all
// in-flight samples whenever the delay is reprogrammed.
module prog_delay_line #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH_BITS    = 4,
    parameter int DEFAULT_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  in_valid,
    input  logic                  delay_ld,
    input  logic [DEPTH_BITS:0]   delay_val,
    output logic [DEPTH_BITS:0]   delay_cur,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid
);

    localparam int MAX_DEPTH = 1 << DEPTH_BITS;

    // Sample storage and the per-slot valid tags that travel with it.
    logic [DATA_WIDTH-1:0] mem [MAX_DEPTH];
    logic [MAX_DEPTH-1:0]  tag;
    logic [MAX_DEPTH-1:0]  tag_nxt;

    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   rd_diff;
    logic [DEPTH_BITS:0]   delay_new;

    // Clamp the requested delay into 1..MAX_DEPTH and derive the read slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        delay_new = delay_val;
        if (delay_val == '0) begin
            delay_new = (DEPTH_BITS+1)'(1);
        end else if (delay_val > (DEPTH_BITS+1)'(MAX_DEPTH)) begin
            delay_new = (DEPTH_BITS+1)'(MAX_DEPTH);
        end
        // The write slot is D enabled edges ahead of the slot holding the
        // sample due now; the subtraction wraps naturally modulo MAX_DEPTH.
        rd_diff = {1'b0, wr_ptr} - delay_cur;
        rd_ptr  = rd_diff[DEPTH_BITS-1:0];
    end

    // Next valid-tag vector: a reload wipes every tag, then an enabled edge
    // records the tag of the incoming sample (possibly the first under a new delay).
    always_comb begin
        tag_nxt = delay_ld ? '0 : tag;
        if (en) begin
            tag_nxt[wr_ptr] = in_valid;
        end
    end

    // Sample storage write; contents are only ever used when their tag is set.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; validity lives in the tag bits,
        // which keeps this a plain RAM with no per-word reset logic.
        if (!clr && en) begin
            mem[wr_ptr] <= in;
        end
    end

    // Control state: delay register, pointer, tags and the masked output register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, regardless of statement order.
        if (clr) begin
            delay_cur <= (DEPTH_BITS+1)'(DEFAULT_DELAY);
            tag       <= '0;
            wr_ptr    <= '0;
            out       <= '0;
            out_valid <= '0;
        end else begin
            tag <= tag_nxt;
            if (en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (delay_ld) begin
                delay_cur <= delay_new;
                out       <= '0;
                out_valid <= 1'b0;
            end else if (en) begin
                out_valid <= tag[rd_ptr];
                out       <= tag[rd_ptr] ? mem[rd_ptr] : '0;
            end
        end
    end

endmodule
